// File: rtl/loader_pkg.sv
// Shared types and stream framing constants for the program loader.
// The stream is a 2-byte little-endian length header followed by one byte pair per instruction word.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    INS_LO,
    INS_HI,
    RUN,
    FINISHED,
    ERROR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 2;

  // Bits of an instruction high byte that must be zero (only bit 0 carries data).
  localparam logic [7:0] HI_BYTE_PAD_MASK = 8'hFE;

  function automatic logic is_loading(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == INS_LO) || (s == INS_HI);
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Assembles a low/high byte pair into one W-bit instruction word and issues
// a single-cycle ROM write strobe when the high byte passes the pad check.
module instr_packer
  import loader_pkg::*;
#(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lo_en,
  input  logic         hi_en,
  input  logic [7:0]   byte_in,
  input  logic [D-1:0] index,
  output logic         pad_ok,
  output logic         wr_en,
  output logic [D-1:0] addr,
  output logic [W-1:0] data
);

  logic [7:0] lo_q;

  assign pad_ok = (byte_in & HI_BYTE_PAD_MASK) == 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q  <= '0;
      wr_en <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      wr_en <= hi_en & pad_ok;
      if (lo_en) lo_q <= byte_in;
      if (hi_en && pad_ok) begin
        addr <= index;
        data <= {byte_in[W-9:0], lo_q};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into the instruction ROM, releases the
// core from reset, and measures the run length until the core reports done.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned D  = 12,
  parameter int unsigned W  = 9,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_wr_en,
  output logic [D-1:0]  imem_addr,
  output logic [W-1:0]  imem_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          error,
  output logic [CW-1:0] cycle_count
);

  state_t state, state_n;

  logic          xfer;
  logic          accept_start;
  logic          lo_en, hi_en, pad_ok;
  logic          len_hi_bad;
  logic [7:0]    len_lo;
  logic [D-1:0]  len, len_full, idx;
  logic [CW-1:0] cnt_inc;

  assign xfer         = in_valid & in_ready;
  assign accept_start = start && ((state == IDLE) || (state == FINISHED) || (state == ERROR));
  assign lo_en        = xfer && (state == INS_LO);
  assign hi_en        = xfer && (state == INS_HI);
  assign len_hi_bad   = in_data[7:D-8] != '0;
  assign len_full     = {in_data[D-9:0], len_lo};
  assign cnt_inc      = cycle_count + CW'(1);

  instr_packer #(
    .D(D),
    .W(W)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .lo_en  (lo_en),
    .hi_en  (hi_en),
    .byte_in(in_data),
    .index  (idx),
    .pad_ok (pad_ok),
    .wr_en  (imem_wr_en),
    .addr   (imem_addr),
    .data   (imem_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, FINISHED, ERROR: if (start) state_n = LEN_LO;
      LEN_LO: if (xfer) state_n = LEN_HI;
      LEN_HI: if (xfer) state_n = (len_hi_bad || len_full == '0) ? ERROR : INS_LO;
      INS_LO: if (xfer) state_n = INS_HI;
      INS_HI: begin
        if (xfer) begin
          if (!pad_ok)                state_n = ERROR;
          else if (idx == len - D'(1)) state_n = RUN;
          else                        state_n = INS_LO;
        end
      end
      // First RUN edge only releases core_reset; done/timeout count from then on.
      RUN: begin
        if (!core_reset) begin
          if (core_done)           state_n = FINISHED;
          else if (cnt_inc == '1)  state_n = ERROR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready    <= 1'b0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      finished    <= 1'b0;
      error       <= 1'b0;
      cycle_count <= '0;
      len_lo      <= '0;
      len         <= '0;
      idx         <= '0;
    end else begin
      in_ready   <= is_loading(state_n);
      busy       <= is_loading(state_n) || (state_n == RUN);
      finished   <= state_n == FINISHED;
      error      <= state_n == ERROR;
      core_reset <= !((state == RUN) && (state_n == RUN));

      if (accept_start)                             cycle_count <= '0;
      else if ((state == RUN) && !core_reset)       cycle_count <= cnt_inc;

      if (xfer && (state == LEN_LO)) len_lo <= in_data;
      if (xfer && (state == LEN_HI)) len    <= len_full;

      if (accept_start)          idx <= '0;
      else if (hi_en && pad_ok)  idx <= idx + D'(1);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected ROM writes are queued as bytes are
// driven and popped by a monitor whenever the write strobe is seen.
module tb_prog_loader;

  localparam int unsigned D  = 12;
  localparam int unsigned W  = 9;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_wr_en;
  logic [D-1:0]  imem_addr;
  logic [W-1:0]  imem_data;
  logic          core_reset;
  logic          core_done = 1'b0;
  logic          busy;
  logic          finished;
  logic          error;
  logic [CW-1:0] cycle_count;

  prog_loader #(
    .D (D),
    .W (W),
    .CW(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_wr_en (imem_wr_en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .core_reset (core_reset),
    .core_done  (core_done),
    .busy       (busy),
    .finished   (finished),
    .error      (error),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t        sb[$];
  wr_t        exp_w;
  logic [7:0] stim[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && imem_wr_en) begin
      if (sb.size() == 0) begin
        check_val("unexpected_write", 64'd1, 64'd0);
      end else begin
        exp_w = sb.pop_front();
        check_val("wr_addr", 64'(imem_addr), 64'(exp_w.addr));
        check_val("wr_data", 64'(imem_data), 64'(exp_w.data));
      end
    end
  end

  task automatic push_wr(input logic [D-1:0] a, input logic [W-1:0] d);
    sb.push_back('{addr: a, data: d});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_val("in_ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // bp: idle cycle with garbage between bytes; start_at: byte index whose gap also pulses start.
  task automatic send_stream(input bit bp, input int start_at);
    for (int i = 0; i < stim.size(); i++) begin
      if (bp && i > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = (i == start_at);
        @(posedge clk);
        #1 start = 1'b0;
      end
      send_byte(stim[i]);
    end
  endtask

  // Entered at #1 after the final write strobe edge; done lands on the n-th edge after core_reset falls.
  task automatic run_core(input int n, input bit with_start);
    check_val("core_rst_at_strobe", 64'(core_reset), 64'd1);
    @(posedge clk);
    #1;
    check_val("core_rst_fall", 64'(core_reset), 64'd0);
    check_val("busy_in_run", 64'(busy), 64'd1);
    repeat (n - 1) @(posedge clk);
    #1;
    core_done = 1'b1;
    start     = with_start;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    start     = 1'b0;
    check_val("finished", 64'(finished), 64'd1);
    check_val("busy_after_done", 64'(busy), 64'd0);
    check_val("cycle_count", 64'(cycle_count), 64'(n));
    check_val("core_rst_after_done", 64'(core_reset), 64'd1);
    check_val("error_after_done", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    check_val("finished_held", 64'(finished), 64'd1);
    check_val("no_reload", 64'(in_ready), 64'd0);
  endtask

  task automatic check_error_state(input string tag);
    check_val({tag, "_error"}, 64'(error), 64'd1);
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_core_rst"}, 64'(core_reset), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_wr_en"}, 64'(imem_wr_en), 64'd0);
    check_val({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check_val({tag, "_data"}, 64'(imem_data), 64'd0);
    check_val({tag, "_core_rst"}, 64'(core_reset), 64'd1);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_finished"}, 64'(finished), 64'd0);
    check_val({tag, "_error"}, 64'(error), 64'd0);
    check_val({tag, "_count"}, 64'(cycle_count), 64'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check_val({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Clean 3-word load and a 10-cycle run.
    pulse_start();
    check_val("busy_on_start", 64'(busy), 64'd1);
    check_val("in_ready_on_start", 64'(in_ready), 64'd1);
    push_wr(12'd0, 9'h012);
    push_wr(12'd1, 9'h134);
    push_wr(12'd2, 9'h0FF);
    stim = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
    send_stream(1'b0, -1);
    run_core(10, 1'b0);
    drain("clean");

    // Pad violation on the second word, then a clean reload.
    pulse_start();
    check_val("finished_cleared", 64'(finished), 64'd0);
    check_val("count_cleared", 64'(cycle_count), 64'd0);
    push_wr(12'd0, 9'h012);
    stim = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h02};
    send_stream(1'b0, -1);
    check_error_state("pad");
    drain("pad");
    pulse_start();
    check_val("error_cleared", 64'(error), 64'd0);
    push_wr(12'd0, 9'h155);
    stim = '{8'h01, 8'h00, 8'h55, 8'h01};
    send_stream(1'b0, -1);
    run_core(3, 1'b0);
    drain("reload");

    // Bad length headers.
    pulse_start();
    stim = '{8'h00, 8'h00};
    send_stream(1'b0, -1);
    check_error_state("len_zero");
    pulse_start();
    stim = '{8'h05, 8'h10};
    send_stream(1'b0, -1);
    check_error_state("len_hi");
    drain("len");

    // Backpressure with a stray start mid-load; start collides with done at the end.
    pulse_start();
    push_wr(12'd0, 9'h012);
    push_wr(12'd1, 9'h134);
    push_wr(12'd2, 9'h0FF);
    stim = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
    send_stream(1'b1, 4);
    run_core(5, 1'b1);
    drain("bp");

    // Asynchronous reset after two words, between clock edges.
    pulse_start();
    push_wr(12'd0, 9'h012);
    stim = '{8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01};
    send_stream(1'b0, -1);
    check_val("pre_reset_strobe", 64'(imem_wr_en), 64'd1);
    check_val("pre_reset_addr", 64'(imem_addr), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    check_val("async_sb_empty", 64'(sb.size()), 64'd0);
    pulse_start();
    push_wr(12'd0, 9'h0AA);
    stim = '{8'h01, 8'h00, 8'hAA, 8'h00};
    send_stream(1'b0, -1);
    run_core(4, 1'b0);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
